// File: rtl/sar_adc_if.sv
// sar_adc_if: handshake and data lines between the SAR controller (master) and the analog front end (slave).
interface sar_adc_if #(parameter int WIDTH = 8);
  logic go;
  logic cmp;
  logic sample;
  logic valid;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] result;
  modport master (input go, cmp, output sample, value, result, valid);
  modport slave (output go, cmp, input sample, value, result, valid);
endinterface

// File: rtl/sar_adc_controller.sv
// sar_adc_controller: successive-approximation control, one bit decided per clock after a one-cycle sample phase.
module sar_adc_controller #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  sar_adc_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, SAMPLE = 2'b01, CONV = 2'b10, DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, mask_q, mask_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      result_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      mask_q <= mask_d;
    end
  end
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    mask_d = mask_q;
    case (state_q)
      IDLE: state_d = bus.go ? SAMPLE : IDLE;
      SAMPLE: begin
        result_d = '0;
        mask_d = {1'b1, {(WIDTH-1){1'b0}}};
        state_d = CONV;
      end
      CONV: begin
        result_d = bus.cmp ? (result_q | mask_q) : result_q;
        mask_d = mask_q >> 1;
        state_d = mask_q[0] ? DONE : CONV;
      end
      DONE: state_d = bus.go ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.sample = (state_q == SAMPLE);
  assign bus.valid = (state_q == DONE);
  assign bus.value = result_q | mask_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_sar_adc_controller.sv
// tb_sar_adc_controller: randomized SAR conversions against a binary-search reference with a modelled S/H and comparator.
module tb_sar_adc_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] analog = 8'h00;
  logic [7:0] hold = 8'h00;
  int pass_cnt = 0;
  int total_cnt = 0;
  sar_adc_if #(.WIDTH(8)) bus ();
  sar_adc_controller #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge bus.sample) hold <= analog;
  assign bus.cmp = (hold >= bus.value);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic run_conversion(input logic [7:0] a, input int go_cycles);
    logic [7:0] trial [8];
    logic [7:0] acc;
    int k;
    acc = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      trial[7-b] = acc | 8'(1 << b);
      if (a >= trial[7-b]) acc = trial[7-b];
    end
    @(negedge clk);
    analog = a;
    bus.go = 1'b1;
    k = 0;
    @(negedge clk);
    k++;
    if (k == go_cycles) bus.go = 1'b0;
    total_cnt++;
    if (bus.sample !== 1'b1 || bus.valid !== 1'b0) $display("FAIL sample_rise: sample=%b valid=%b expected 1/0", bus.sample, bus.valid);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      k++;
      if (k == go_cycles) bus.go = 1'b0;
      total_cnt++;
      if (bus.value !== trial[i] || bus.sample !== 1'b0 || bus.valid !== 1'b0)
        $display("FAIL value_step%0d: value=%h sample=%b valid=%b expected value=%h sample=0 valid=0", i, bus.value, bus.sample, bus.valid, trial[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (bus.valid !== 1'b1 || bus.result !== acc)
      $display("FAIL done_result: valid=%b result=%h expected valid=1 result=%h", bus.valid, bus.result, acc);
    else pass_cnt++;
  endtask

  task automatic idle_go_low(input logic [7:0] last);
    @(negedge clk);
    bus.go = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.valid !== 1'b0 || bus.result !== last || bus.sample !== 1'b0)
      $display("FAIL idle_return: valid=%b result=%h sample=%b expected 0/%h/0", bus.valid, bus.result, bus.sample, last);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    bus.go = 1'b0;
    rst_n = 1'b0;
    #100;
    chk("reset_valid", 32'(bus.valid), 0);
    chk("reset_sample", 32'(bus.sample), 0);
    chk("reset_value", 32'(bus.value), 0);
    chk("reset_result", 32'(bus.result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_go", {bus.sample, bus.valid, bus.value}, 0);
  endtask

  task automatic test_basic;
    run_conversion(8'h19, 1000);
  endtask

  task automatic test_hold_go;
    int bad;
    bad = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.valid !== 1'b1 || bus.sample !== 1'b0 || bus.result !== 8'h19) bad++;
    end
    chk("hold_go_done", bad, 0);
  endtask

  task automatic test_rearm;
    idle_go_low(8'h19);
    chk("idle_value", 32'(bus.value), 32'h19);
    run_conversion(8'h19, 2);
    idle_go_low(8'h19);
  endtask

  task automatic test_boundaries;
    run_conversion(8'h00, 1);
    idle_go_low(8'h00);
    run_conversion(8'hFF, 1000);
    idle_go_low(8'hFF);
  endtask

  task automatic test_random;
    logic [7:0] a;
    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom);
      run_conversion(a, int'($urandom_range(1, 12)));
      idle_go_low(a);
    end
  endtask

  task automatic test_reset_mid_conv;
    logic [7:0] a;
    @(negedge clk);
    analog = 8'hA5;
    bus.go = 1'b1;
    repeat (5) @(negedge clk);
    bus.go = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {bus.sample, bus.valid, bus.value, bus.result}, 0);
    @(negedge clk);
    chk("midreset_held", {bus.sample, bus.valid, bus.value, bus.result}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {bus.sample, bus.valid, bus.value}, 0);
    a = 8'($urandom);
    run_conversion(a, 3);
    idle_go_low(a);
  endtask

  initial begin
    bus.go = 1'b0;
    test_reset;
    test_basic;
    test_hold_go;
    test_rearm;
    test_boundaries;
    test_random;
    test_reset_mid_conv;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
